// File: rtl/qc_ldpc_pkg.sv
// qc_ldpc_pkg
// Constants and types shared by the QC-LDPC encoder data path and its
// codeword serializer: frame geometry (K info bits, P parity bits,
// N = K + P codeword bits), serializer counter width and FSM state type.
package qc_ldpc_pkg;

  localparam int unsigned K     = 33;
  localparam int unsigned P     = 32;
  localparam int unsigned N     = K + P;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COLLECT     = 2'd1,
    WAIT_PARITY = 2'd2,
    SEND        = 2'd3
  } state_t;

endpackage

// File: rtl/qc_ldpc_shift_reg.sv
// qc_ldpc_shift_reg
// Left-shifting register used to hold one codeword.
//   clk, rst      : clock, asynchronous active-high reset (clears contents)
//   shift_in_en   : shift left by one, shift_in_bit enters at the LSB
//   shift_in_bit  : serial input bit
//   load_en       : shift left by LW, load_data fills the low LW bits
//   load_data     : partial parallel load value
//   shift_en      : shift left by one, zero enters at the LSB
//   msb           : current bit W-1 (next bit to transmit)
// Enables are expected to be mutually exclusive; load has priority.
module qc_ldpc_shift_reg #(
  parameter int unsigned W  = 65,
  parameter int unsigned LW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_in_en,
  input  logic          shift_in_bit,
  input  logic          load_en,
  input  logic [LW-1:0] load_data,
  input  logic          shift_en,
  output logic          msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= {q[W-LW-1:0], load_data};
    end else if (shift_in_en) begin
      q <= {q[W-2:0], shift_in_bit};
    end else if (shift_en) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/qc_ldpc_codeword_serializer.sv
// qc_ldpc_codeword_serializer
// Snoops the serial information bits fed to the QC-LDPC encoder, captures
// the parity vector on enc_done and streams the systematic codeword
// (K info bits first-received first, then parity MSB first) one bit per
// valid/ready transfer.
//   clk, rst      : clock, asynchronous active-high reset
//   info_bit      : serial information bit (shared with the encoder)
//   info_valid    : qualifies info_bit
//   enc_done      : encoder done, parity_vector valid while high
//   parity_vector : encoder parity, bit P-1 transmitted first
//   out_bit       : codeword bit
//   out_valid     : out_bit valid
//   out_ready     : downstream accepts with out_valid
//   out_last      : final codeword bit of the frame
//   busy          : FSM not in IDLE
//   err           : one-cycle pulse on a protocol violation
module qc_ldpc_codeword_serializer
  import qc_ldpc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         info_bit,
  input  logic         info_valid,
  input  logic         enc_done,
  input  logic [P-1:0] parity_vector,
  output logic         out_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         err
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             err_nx;
  logic             sr_shift_in, sr_load, sr_shift;
  logic             cw_msb;

  qc_ldpc_shift_reg #(
    .W  (N),
    .LW (P)
  ) u_cw (
    .clk          (clk),
    .rst          (rst),
    .shift_in_en  (sr_shift_in),
    .shift_in_bit (info_bit),
    .load_en      (sr_load),
    .load_data    (parity_vector),
    .shift_en     (sr_shift),
    .msb          (cw_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    err_nx      = 1'b0;
    sr_shift_in = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enc_done) err_nx = 1'b1;
        if (info_valid) begin
          sr_shift_in = 1'b1;
          cnt_nx      = CNT_W'(1);
          state_nx    = COLLECT;
        end
      end
      COLLECT: begin
        if (enc_done) err_nx = 1'b1;
        if (info_valid) begin
          sr_shift_in = 1'b1;
          cnt_nx      = cnt + 1'b1;
          if (cnt == CNT_W'(K - 1)) state_nx = WAIT_PARITY;
        end
      end
      WAIT_PARITY: begin
        if (info_valid) err_nx = 1'b1;
        if (enc_done) begin
          sr_load  = 1'b1;
          cnt_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        // No frame overlap: any upstream activity while sending is dropped.
        if (info_valid || enc_done) err_nx = 1'b1;
        if (out_ready) begin
          sr_shift = 1'b1;
          cnt_nx   = cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs decode registered state only; reset forces IDLE so out_valid
  // drops as soon as rst rises.
  assign out_valid = (state == SEND);
  assign out_bit   = out_valid & cw_msb;
  assign out_last  = out_valid && (cnt == CNT_W'(N - 1));
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_qc_ldpc_codeword_serializer.sv
// tb_qc_ldpc_codeword_serializer
// Directed bench for qc_ldpc_codeword_serializer: nominal frame,
// backpressure, early done, overrun, reset mid-send and back-to-back frames.
module tb_qc_ldpc_codeword_serializer;
  import qc_ldpc_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         info_bit = 1'b0;
  logic         info_valid = 1'b0;
  logic         enc_done = 1'b0;
  logic [P-1:0] parity_vector = '0;
  logic         out_bit;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;
  logic         err;

  int n_vec = 0;
  int n_err = 0;
  int err_cnt = 0;

  localparam logic [K-1:0] INFO_A = 33'b110000111111000101001101110110111;
  localparam logic [P-1:0] PAR_A  = 32'hA5A5_0F0F;
  localparam logic [K-1:0] INFO_B = 33'h1_3C5A_9E01;
  localparam logic [P-1:0] PAR_B  = 32'h1234_5678;

  logic [N-1:0] cw_a, cw_b;
  logic [3:0]   rdy_pat = 4'b1001;

  qc_ldpc_codeword_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .info_bit      (info_bit),
    .info_valid    (info_valid),
    .enc_done      (enc_done),
    .parity_vector (parity_vector),
    .out_bit       (out_bit),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // Feed info bits hi..lo of a frame, one per cycle.
  task automatic send_bits(input logic [K-1:0] info, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      info_valid = 1'b1;
      info_bit   = info[i];
      step();
    end
    info_valid = 1'b0;
    info_bit   = 1'b0;
  endtask

  task automatic pulse_done(input logic [P-1:0] par);
    enc_done      = 1'b1;
    parity_vector = par;
    step();
    enc_done      = 1'b0;
  endtask

  // Accept n_xfer codeword bits, optionally with the 1,0,0,1 ready pattern.
  task automatic drain(input string name, input logic [N-1:0] cw, input bit bp,
                       input int unsigned n_xfer);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    while (idx < n_xfer && cyc < 400) begin
      out_ready = bp ? rdy_pat[cyc % 4] : 1'b1;
      check({name, " valid"}, 32'(out_valid), 32'd1);
      check({name, " bit"},   32'(out_bit),   32'(cw[N-1-idx]));
      check({name, " last"},  32'(out_last),  32'(idx == N - 1));
      step();
      if (out_ready) idx++;
      cyc++;
    end
    out_ready = 1'b1;
    check({name, " xfers"}, idx, n_xfer);
    if (n_xfer == N) begin
      check({name, " valid after"}, 32'(out_valid), 32'd0);
      check({name, " busy after"},  32'(busy),      32'd0);
      check({name, " last after"},  32'(out_last),  32'd0);
    end
  endtask

  task automatic frame(input string name, input logic [K-1:0] info, input logic [P-1:0] par,
                       input logic [N-1:0] cw, input bit bp);
    send_bits(info, K - 1, 0);
    check({name, " wait busy"},  32'(busy),      32'd1);
    check({name, " wait valid"}, 32'(out_valid), 32'd0);
    pulse_done(par);
    drain(name, cw, bp, N);
  endtask

  initial begin
    cw_a = {INFO_A, PAR_A};
    cw_b = {INFO_B, PAR_B};

    // Reset state
    idle(3);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_bit",   32'(out_bit),   32'd0);
    check("rst out_last",  32'(out_last),  32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst err",       32'(err),       32'd0);
    rst = 1'b0;
    idle(2);

    // Nominal
    frame("nom", INFO_A, PAR_A, cw_a, 1'b0);
    idle(2);
    check("nom err_cnt", err_cnt, 0);

    // Backpressure
    frame("bp", INFO_A, PAR_A, cw_a, 1'b1);
    idle(2);
    check("bp err_cnt", err_cnt, 0);

    // Early done after 10 info bits
    send_bits(INFO_A, K - 1, K - 10);
    pulse_done(32'hFFFF_FFFF);
    check("early err",   32'(err),       32'd1);
    check("early busy",  32'(busy),      32'd1);
    check("early valid", 32'(out_valid), 32'd0);
    step();
    check("early err clr", 32'(err), 32'd0);
    send_bits(INFO_A, K - 11, 0);
    check("early wait valid", 32'(out_valid), 32'd0);
    pulse_done(PAR_A);
    drain("early", cw_a, 1'b0, N);
    idle(2);
    check("early err_cnt", err_cnt, 1);

    // Overrun: info in WAIT_PARITY, held done and info in SEND
    send_bits(INFO_A, K - 1, 0);
    info_valid = 1'b1;
    info_bit   = ~INFO_A[0];
    step();
    info_valid = 1'b0;
    check("ovr wait err",   32'(err),       32'd1);
    check("ovr wait valid", 32'(out_valid), 32'd0);
    out_ready     = 1'b0;
    enc_done      = 1'b1;
    parity_vector = PAR_A;
    step();
    check("ovr capture err", 32'(err),       32'd0);
    check("ovr capture vld", 32'(out_valid), 32'd1);
    parity_vector = 32'h0000_0000;
    step();
    enc_done = 1'b0;
    check("ovr held done err", 32'(err), 32'd1);
    info_valid = 1'b1;
    info_bit   = 1'b0;
    step();
    info_valid = 1'b0;
    check("ovr send err", 32'(err), 32'd1);
    drain("ovr", cw_a, 1'b0, N);
    idle(2);
    check("ovr err_cnt", err_cnt, 4);

    // Reset after 20 transfers
    send_bits(INFO_A, K - 1, 0);
    pulse_done(PAR_A);
    drain("pre rst", cw_a, 1'b0, 20);
    #2 rst = 1'b1;
    #1;
    check("midrst valid", 32'(out_valid), 32'd0);
    check("midrst busy",  32'(busy),      32'd0);
    check("midrst last",  32'(out_last),  32'd0);
    step();
    rst = 1'b0;
    idle(1);
    frame("post rst", INFO_B, PAR_B, cw_b, 1'b0);
    idle(2);
    check("post rst err_cnt", err_cnt, 4);

    // Back-to-back: frame 2 starts in the cycle after frame 1 out_last
    frame("b2b 1", INFO_A, PAR_A, cw_a, 1'b0);
    frame("b2b 2", INFO_B, PAR_B, cw_b, 1'b1);
    idle(2);
    check("b2b err_cnt", err_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
